// File: rtl/alu_writeback_pkg.sv
// rtl/alu_writeback_pkg.sv - shared opcode, flag and width definitions for the ALU writeback stage
package alu_writeback_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int OPCODE_W   = 6;

  // Bit positions inside the {Z,N,C,O} flag nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  // Legal opcode window is OP_ADD..OP_DEC; opcodes are compared as 8-bit values
  localparam logic [7:0] OP_ADD = 8'h0A;
  localparam logic [7:0] OP_MOV = 8'h10;
  localparam logic [7:0] OP_CMP = 8'h18;
  localparam logic [7:0] OP_TST = 8'h19;
  localparam logic [7:0] OP_INC = 8'h1A;
  localparam logic [7:0] OP_DEC = 8'h1B;

  typedef enum logic [1:0] {
    CLS_WRITE   = 2'd0,
    CLS_NOWRITE = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_e;

  // CMP/TST only produce flags; everything else inside the window writes a register
  function automatic op_class_e classify(input logic [7:0] op);
    if (op == OP_CMP || op == OP_TST)
      return CLS_NOWRITE;
    else if (op >= OP_ADD && op <= OP_DEC)
      return CLS_WRITE;
    else
      return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_writeback_wb_skid_buf.sv
// rtl/alu_writeback_wb_skid_buf.sv - 2-entry skid FIFO holding packed {opcode,dest,result,flags} entries
module wb_skid_buf #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic [W-1:0] second_data,
  output logic         head_valid,
  output logic         second_valid,
  output logic         ready
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign ready        = (cnt != 2'd2);
  assign head_valid   = (cnt != 2'd0);
  assign second_valid = (cnt == 2'd2);
  assign do_push      = push && ready;
  assign do_pop       = pop && head_valid;
  assign head_data    = mem[rd_ptr];
  assign second_data  = mem[~rd_ptr];

  // Pointer/count update; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback stage: skid buffer, regfile write handshake, flag register (option FLAG_FWD_EN)
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W     = alu_writeback_pkg::DATA_W,
  parameter int REG_ADDR_W = alu_writeback_pkg::REG_ADDR_W,
  parameter int OPCODE_W   = alu_writeback_pkg::OPCODE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_W-1:0]      in_opcode,
  input  logic [REG_ADDR_W-1:0]    in_dest,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [3:0]               in_flags,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [REG_ADDR_W-1:0]    wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [3:0]               flags_out,
  output logic [2**REG_ADDR_W-1:0] pending_mask,
  output logic                     illegal_op
);

  localparam int EW = OPCODE_W + REG_ADDR_W + DATA_W + 4;

  logic [EW-1:0]         head_data;
  logic [EW-1:0]         second_data;
  logic                  head_valid;
  logic                  second_valid;
  logic [OPCODE_W-1:0]   head_op;
  logic [REG_ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0]     head_result;
  logic [3:0]            head_flags;
  logic [OPCODE_W-1:0]   second_op;
  logic [REG_ADDR_W-1:0] second_dest;
  op_class_e             head_cls;
  op_class_e             second_cls;
  logic                  retire;
  logic                  flag_upd;
  logic [3:0]            flag_reg;

  wb_skid_buf #(.W(EW)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .push         (in_valid && !flush),
    .pop          (retire),
    .push_data    ({in_opcode, in_dest, in_result, in_flags}),
    .head_data    (head_data),
    .second_data  (second_data),
    .head_valid   (head_valid),
    .second_valid (second_valid),
    .ready        (in_ready)
  );

  assign {head_op, head_dest, head_result, head_flags} = head_data;
  assign second_op   = second_data[EW-1 -: OPCODE_W];
  assign second_dest = second_data[EW-OPCODE_W-1 -: REG_ADDR_W];

  assign head_cls   = classify(8'(head_op));
  assign second_cls = classify(8'(second_op));

  // Non-writing heads leave in their first head cycle; writes wait for the regfile
  assign wb_valid = head_valid && (head_cls == CLS_WRITE);
  assign retire   = head_valid && ((head_cls != CLS_WRITE) || wb_ready);
  assign flag_upd = retire && (head_cls != CLS_ILLEGAL) && (8'(head_op) != OP_MOV);
  assign wb_addr  = wb_valid ? head_dest   : '0;
  assign wb_data  = wb_valid ? head_result : '0;

  // Destinations of every buffered register-writing entry, for RAW stalls upstream
  always_comb begin
    pending_mask = '0;
    if (head_valid && head_cls == CLS_WRITE)
      pending_mask[head_dest] = 1'b1;
    if (second_valid && second_cls == CLS_WRITE)
      pending_mask[second_dest] = 1'b1;
  end

  // Architectural flags and the illegal-opcode pulse, both driven by retirement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg   <= 4'b0000;
      illegal_op <= 1'b0;
    end else begin
      if (flag_upd)
        flag_reg <= head_flags;
      illegal_op <= retire && (head_cls == CLS_ILLEGAL);
    end
  end

`ifdef FLAG_FWD_EN
  assign flags_out = flag_upd ? head_flags : flag_reg;
`else
  assign flags_out = flag_reg;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - self-checking bench for alu_writeback against a queue-based reference model
module tb_alu_writeback;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [2:0]  in_dest;
  logic [15:0] in_result;
  logic [3:0]  in_flags;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  flags_out;
  logic [7:0]  pending_mask;
  logic        illegal_op;

  alu_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_dest      (in_dest),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flags_out    (flags_out),
    .pending_mask (pending_mask),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [2:0]  dest;
    logic [15:0] res;
    logic [3:0]  fl;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_flags;
  logic       m_ill;
  int         compared;
  int         mismatched;

  function automatic bit is_write(input logic [5:0] op);
    return (op >= 6'h0A && op <= 6'h17) || op == 6'h1A || op == 6'h1B;
  endfunction

  function automatic bit is_nowrite(input logic [5:0] op);
    return op == 6'h18 || op == 6'h19;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_flags", 32'(flags_out), 32'd0);
    check("rst_pending", 32'(pending_mask), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // One clock: drive at negedge, check this cycle's outputs, then advance the model at the edge
  task automatic cyc(input logic v, input logic [5:0] op, input logic [2:0] dest,
                     input logic [15:0] res, input logic [3:0] fl,
                     input logic wbr, input logic fsh);
    bit         have;
    bit         wr;
    bit         retire_now;
    bit         upd;
    bit         accept;
    ent_t       h;
    ent_t       e;
    logic [7:0] mask;
    logic [3:0] exp_flags;
    in_valid  = v;
    in_opcode = op;
    in_dest   = dest;
    in_result = res;
    in_flags  = fl;
    wb_ready  = wbr;
    flush     = fsh;
    #1;
    have = (q.size() > 0);
    h    = have ? q[0] : '{op: 6'd0, dest: 3'd0, res: 16'd0, fl: 4'd0};
    wr   = have && is_write(h.op);
    mask = 8'd0;
    foreach (q[i]) if (is_write(q[i].op)) mask[q[i].dest] = 1'b1;
    retire_now = have && (!wr || wbr);
    upd = retire_now && (is_write(h.op) || is_nowrite(h.op)) && h.op != 6'h10;
    exp_flags = m_flags;
`ifdef FLAG_FWD_EN
    if (upd) exp_flags = h.fl;
`endif
    check("wb_valid", 32'(wb_valid), 32'(wr));
    check("wb_addr", 32'(wb_addr), wr ? 32'(h.dest) : 32'd0);
    check("wb_data", 32'(wb_data), wr ? 32'(h.res) : 32'd0);
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("pending_mask", 32'(pending_mask), 32'(mask));
    check("flags_out", 32'(flags_out), 32'(exp_flags));
    check("illegal_op", 32'(illegal_op), 32'(m_ill));
    @(posedge clk);
    accept = v && (q.size() < 2) && !fsh;
    m_ill  = retire_now && !is_write(h.op) && !is_nowrite(h.op);
    if (upd) m_flags = h.fl;
    if (retire_now) void'(q.pop_front());
    if (fsh) q.delete();
    if (accept) begin
      e = '{op: op, dest: dest, res: res, fl: fl};
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic wbr);
    cyc(1'b0, 6'h00, 3'd0, 16'h0000, 4'h0, wbr, 1'b0);
  endtask

  initial begin
    logic [5:0] rop;
    compared   = 0;
    mismatched = 0;
    m_flags    = 4'h0;
    m_ill      = 1'b0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_opcode  = 6'h00;
    in_dest    = 3'd0;
    in_result  = 16'h0000;
    in_flags   = 4'h0;
    wb_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // ADD, CMP, MOV sequence
    cyc(1'b1, 6'h0A, 3'd3, 16'h1234, 4'b0000, 1'b1, 1'b0);
    idle(1'b1);
    cyc(1'b1, 6'h18, 3'd1, 16'hAAAA, 4'b1000, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    cyc(1'b1, 6'h10, 3'd2, 16'h00FF, 4'b0001, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stall with three pushes, then drain in order
    cyc(1'b1, 6'h0B, 3'd1, 16'h1111, 4'b0100, 1'b0, 1'b0);
    cyc(1'b1, 6'h0C, 3'd2, 16'h2222, 4'b0010, 1'b0, 1'b0);
    cyc(1'b1, 6'h0D, 3'd4, 16'h4444, 4'b0001, 1'b0, 1'b0);
    idle(1'b0);
    repeat (4) idle(1'b1);

    // Two writes to the same register, then flush
    cyc(1'b1, 6'h1A, 3'd5, 16'h5555, 4'b1111, 1'b0, 1'b0);
    cyc(1'b1, 6'h1B, 3'd5, 16'h5556, 4'b0110, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b1, 6'h0A, 3'd6, 16'h6666, 4'b0011, 1'b0, 1'b1);
    repeat (2) idle(1'b1);

    // Illegal opcode
    cyc(1'b1, 6'h3F, 3'd7, 16'h7777, 4'b1010, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Asynchronous reset in the middle of a stalled write
    cyc(1'b1, 6'h0E, 3'd2, 16'hBEEF, 4'b1100, 1'b0, 1'b0);
    idle(1'b0);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_values();
    q.delete();
    m_flags = 4'h0;
    m_ill   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) rop = 6'($urandom_range(0, 63));
      else                           rop = 6'($urandom_range(10, 27));
      cyc(1'($urandom_range(0, 1)), rop, 3'($urandom_range(0, 7)),
          16'($urandom), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    repeat (4) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
